// File: rtl/rns_to_binary_127_128_129.sv
// Residue-to-binary converter for {2^N-1, 2^N, 2^N+1} using mixed-radix conversion.
// Optional self-check stage and out_mismatch port enabled by RNS_TO_BIN_SELF_CHECK_EN.
module rns_to_binary_127_128_129 #(
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_r_lo,
    input  logic [N-1:0]   in_r_mid,
    input  logic [N:0]     in_r_hi,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3*N-1:0] out_x,
`ifdef RNS_TO_BIN_SELF_CHECK_EN
    output logic           out_mismatch,
`endif
    output logic           out_err
);
    localparam int W = 3 * N;
    localparam logic [N-1:0]        MOD_LO   = {N{1'b1}};
    localparam logic [N:0]          MOD_HI   = {1'b1, {(N-1){1'b0}}, 1'b1};
    localparam logic signed [N+1:0] MOD_LO_S = $signed({2'b00, MOD_LO});
    localparam logic signed [N+1:0] MOD_HI_S = $signed({1'b0, MOD_HI});

    typedef enum logic [2:0] {IDLE, S_A1, S_A2, S_COMB, S_CHK, DONE} state_t;

    state_t state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic [N-1:0]   a0_q, a0_d;
    logic [N-1:0]   r_lo_q, r_lo_d;
    logic [N:0]     r_hi_q, r_hi_d;
    logic           err_q, err_d;
    logic [N:0]     a1_q, a1_d;
    logic [N-1:0]   a2_q, a2_d;
    logic [W-1:0]   out_x_q, out_x_d;
    logic           out_err_q, out_err_d;
    logic           out_valid_q, out_valid_d;

    logic signed [N+1:0] d1, t_s;
    logic [N-1:0]        t;
    logic [W-1:0]        sum;
    logic                accept;
    logic                unused_bits;

    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = S_A1;
            S_A1:   state_d = S_A2;
            S_A2:   state_d = S_COMB;
`ifdef RNS_TO_BIN_SELF_CHECK_EN
            S_COMB: state_d = S_CHK;
            S_CHK:  state_d = DONE;
`else
            S_COMB: state_d = DONE;
`endif
            DONE:   if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Mixed-radix digits: a1 uses 2^N == -1 mod 2^N+1, a2 uses 2^N == 1 mod 2^N-1
    always_comb begin
        d1 = $signed({2'b00, a0_q}) - $signed({1'b0, r_hi_q});
        if (d1 < 0) d1 = d1 + MOD_HI_S;

        t_s = $signed({2'b00, r_lo_q}) - $signed({2'b00, a0_q}) - $signed({1'b0, a1_q});
        for (int k = 0; k < 3; k++) begin
            if (t_s < 0) t_s = t_s + MOD_LO_S;
        end
        t = t_s[N-1:0];
        if (t == MOD_LO) t = '0;

        sum = W'(a0_q) + (W'(a1_q) << N) + (W'(a2_q) << (2 * N)) + (W'(a2_q) << N);
    end

    assign unused_bits = ^{d1[N+1], t_s[N+1:N]};

`ifdef RNS_TO_BIN_SELF_CHECK_EN
    logic mismatch_q, mismatch_d;
    logic chk_ok;
    assign chk_ok = ((out_x_q % W'(MOD_LO)) == W'(r_lo_q)) &&
                    (out_x_q[N-1:0] == a0_q) &&
                    ((out_x_q % W'(MOD_HI)) == W'(r_hi_q));
`endif

    always_comb begin
        a0_d        = a0_q;
        r_lo_d      = r_lo_q;
        r_hi_d      = r_hi_q;
        err_d       = err_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        out_x_d     = out_x_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = (state_d == IDLE);
`ifdef RNS_TO_BIN_SELF_CHECK_EN
        mismatch_d  = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a0_d   = in_r_mid;
                    r_lo_d = in_r_lo;
                    r_hi_d = in_r_hi;
                    err_d  = (in_r_lo == MOD_LO) || (in_r_hi > MOD_HI);
                end
            end
            S_A1: a1_d = d1[N:0];
            S_A2: a2_d = {t[0], t[N-1:1]};
            S_COMB: begin
                out_x_d   = err_q ? '0 : sum;
                out_err_d = err_q;
`ifndef RNS_TO_BIN_SELF_CHECK_EN
                out_valid_d = 1'b1;
`endif
            end
`ifdef RNS_TO_BIN_SELF_CHECK_EN
            S_CHK: begin
                mismatch_d  = !err_q && !chk_ok;
                out_valid_d = 1'b1;
            end
`endif
            DONE: if (out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            a0_q        <= '0;
            r_lo_q      <= '0;
            r_hi_q      <= '0;
            err_q       <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            out_x_q     <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            a0_q        <= a0_d;
            r_lo_q      <= r_lo_d;
            r_hi_q      <= r_hi_d;
            err_q       <= err_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            out_x_q     <= out_x_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef RNS_TO_BIN_SELF_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end
    assign out_mismatch = mismatch_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_err   = out_err_q;
endmodule

// File: doc/rns_to_binary_127_128_129.md
Name: rns_to_binary_127_128_129

Overview:
- Sequential residue-to-binary converter for the moduli set {2^N-1, 2^N, 2^N+1}. With the default N=7 this is {127, 128, 129}.
- It is the inverse of the team's combinational X-mod-129 forward reducers: it rebuilds X in [0, M-1] from three residues, where M = (2^N-1)*2^N*(2^N+1).
- It uses mixed-radix conversion through a small FSM, with valid/ready handshakes on both sides.
- It sits after the RNS datapath, where residue channels return to binary.

Parameters:
- N, default 7: modulus exponent. Moduli are 2^N-1, 2^N and 2^N+1. Legal range 2..16. Output width is 3N.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  residue triple valid.
- in_ready  out  1  block can accept a triple.
- in_r_lo  in  N  X mod (2^N-1).
- in_r_mid  in  N  X mod 2^N.
- in_r_hi  in  N+1  X mod (2^N+1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_x  out  3N  reconstructed X.
- out_err  out  1  input residue was out of range.

Behaviour:
- Reset:
  - One clock domain. Reset is asynchronous and active-low on rst_n.
  - Asserting rst_n low at any time forces state to IDLE and clears in_ready, out_valid, out_x, out_err and all internal registers to 0.
  - Any transaction in flight is dropped; there is no partial output.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States: IDLE, S_A1, S_A2, S_COMB, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready, latch a0=in_r_mid and register r_lo and r_hi, then go to S_A1.
- S_A1:
  - a1 = (a0 - r_hi) mod (2^N+1), using 2^N ≡ -1 mod (2^N+1).
  - Compute in N+2-bit signed arithmetic and add 2^N+1 if negative.
  - Go to S_A2.
- S_A2:
  - t = (r_lo - a0 - a1) mod (2^N-1).
  - Reduce by repeated conditional add of 2^N-1, at most 3 corrections, all inside one cycle.
  - a2 = t * 2^(N-1) mod (2^N-1), implemented as a 1-bit right rotate of the N-bit t.
  - If t == 2^N-1 after reduction, map it to 0 so that a2 ≤ 2^N-2.
  - Go to S_COMB.
- S_COMB:
  - out_x = a0 + a1*2^N + a2*2^N*(2^N+1), computed at width 3N; this cannot overflow.
  - Set out_valid=1 and go to DONE.
- DONE:
  - Hold out_x, out_err and out_valid stable while out_ready=0.
  - On out_valid & out_ready, clear out_valid and return to IDLE. in_ready is high on the following cycle; there is no same-cycle bypass.
- Latency and throughput:
  - out_valid rises exactly 3 clk edges after the accepting edge.
  - Throughput is one result per 5 cycles minimum.
- Input validation:
  - in_r_lo == 2^N-1 or in_r_hi > 2^N is an illegal residue.
  - The triple is still accepted with the same latency, but out_err=1 and out_x=0.
- in_valid, and input changes while in_ready=0, are ignored.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: RNS_TO_BIN_SELF_CHECK_EN.
- Defined:
  - Adds state S_CHK between S_COMB and DONE, so latency becomes 4 edges.
  - S_CHK re-reduces out_x modulo each of the three moduli and compares against the latched residues.
  - Adds output port out_mismatch (1 bit), which has reset value 0 and is valid with out_valid.
  - Illegal-residue triples report out_err=1 and out_mismatch=0.
- Undefined: no S_CHK state, no out_mismatch port, and latency stays 3.

Test Plan:
- Reset then triple (0,0,0) with out_ready=1 -> out_valid 3 cycles after accept, out_x=0, out_err=0.
- (r_lo, r_mid, r_hi) = (2, 64, 121) -> out_x=1000000. Internal values a1=72, a2=60.
- (84, 84, 84) -> out_x=84. Then (126, 127, 128) -> out_x=2097023, which is M-1 and the wrap boundary.
- (127, 5, 5) and, separately, (5, 5, 130) -> out_err=1, out_x=0. The next legal triple (1, 1, 1) -> out_x=1 with out_err=0.
- Backpressure: out_ready=0 for 10 cycles while holding (2, 64, 121) -> out_x stays 1000000, in_ready stays 0, and a second in_valid is ignored until out_ready pulses.
- Reset mid-operation: drive rst_n low in S_A2 -> out_valid never rises for that triple and all outputs are 0 immediately; after release, in_ready=1 and (84, 84, 84) converts normally.
